tlp_tx_arbiter: RTL and testbench

Shares the single 1024-bit TLP channel into the TX data link layer between `NUM_REQ` transaction-layer sources: completions, posted requests, non-posted requests and DLLP-bearing control. Uses round-robin arbitration with a bounded per-requester burst. A one-entry output register decouples the sources from link backpressure. Sits between the TX transaction-layer queues and the data link layer's `tlp_data_in`/`tlp_data_in_valid`/`tlp_data_out_ready` handshake.

---
 rtl/tlp_tx_pkg.sv | 18 +
 rtl/tlp_tx_arbiter_rr_pick.sv | 25 ++
 rtl/tlp_tx_arbiter.sv | 126 ++++++++++++
 tb/tb_tlp_tx_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/tlp_tx_pkg.sv
// Shared types and constants for the TLP transmit arbiter and its helpers.
// Optional build macro: TLP_ARB_CPL_PRIO_EN (completion preemption).
package tlp_tx_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } arb_state_e;

  localparam int NUM_REQ_DEF = 4;
  localparam int REQ_IDX_W   = $clog2(NUM_REQ_DEF);

  localparam int REQ_CPL = 0;
  localparam int REQ_P   = 1;
  localparam int REQ_NP  = 2;
  localparam int REQ_CTL = 3;

endpackage

// File: rtl/tlp_tx_arbiter_rr_pick.sv
// Rotate-priority encoder: first valid requester at or above ptr, wrapping modulo N.
module rr_pick
  import tlp_tx_pkg::*;
#(
  parameter int N = NUM_REQ_DEF,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req_valid,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] sel,
  output logic         any
);

  always_comb begin
    sel = '0;
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!any && req_valid[(int'(ptr) + i) % N]) begin
        any = 1'b1;
        sel = W'((int'(ptr) + i) % N);
      end
    end
  end

endmodule

// File: rtl/tlp_tx_arbiter.sv
// Round-robin TLP arbiter with bounded bursts and a one-entry output register.
// Optional build macro: TLP_ARB_CPL_PRIO_EN gives requester 0 preemptive priority.
module tlp_tx_arbiter
  import tlp_tx_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 1024,
  parameter int MAX_BURST = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [DATA_W-1:0]           tlp_data,
  output logic                        tlp_valid,
  input  logic                        tlp_ready,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        arb_busy
);

  localparam int IDX_W = $clog2(NUM_REQ);

  // Handshake: a source transfers when req_valid[i] && req_ready[i] on a rising edge;
  // the DLL transfers when tlp_valid && tlp_ready.
  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  owner_q, owner_d, rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]  owner_next, pick_ptr, pick_sel, arb_sel, sel;
  logic [3:0]        burst_q, burst_d;
  logic [NUM_REQ-1:0] owner_oh;
  logic              load_en, owner_v, others_v, burst_full, rotate, bump_ptr;
  logic              pick_any, any, hs;
  logic [DATA_W-1:0] req_word;

  assign load_en    = !tlp_valid || tlp_ready;
  assign owner_oh   = NUM_REQ'(1) << owner_q;
  assign owner_v    = |(req_valid & owner_oh);
  assign others_v   = |(req_valid & ~owner_oh);
  assign burst_full = burst_q >= 4'(MAX_BURST);
  assign owner_next = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

`ifdef TLP_ARB_CPL_PRIO_EN
  logic owner_is_cpl;
  assign owner_is_cpl = (owner_q == IDX_W'(REQ_CPL));
  // Completions keep the channel until they drop valid; they never consume rotation.
  assign rotate   = (state_q == STREAM) && load_en &&
                    (!owner_v || (burst_full && others_v && !owner_is_cpl));
  assign bump_ptr = !owner_is_cpl;
  assign arb_sel  = req_valid[REQ_CPL] ? IDX_W'(REQ_CPL) : pick_sel;
`else
  assign rotate   = (state_q == STREAM) && load_en &&
                    (!owner_v || (burst_full && others_v));
  assign bump_ptr = 1'b1;
  assign arb_sel  = pick_sel;
`endif

  // On rotation the search starts just past the old owner in the same cycle.
  assign pick_ptr = rotate ? owner_next : rr_ptr_q;

  rr_pick #(.N(NUM_REQ), .W(IDX_W)) u_pick (
    .req_valid (req_valid),
    .ptr       (pick_ptr),
    .sel       (pick_sel),
    .any       (pick_any)
  );

  always_comb begin
    sel = arb_sel;
    any = pick_any;
    if (state_q == STREAM && !rotate) begin
      sel = owner_q;
      any = owner_v;
    end
  end

  assign hs        = load_en && any && !reset;
  assign req_ready = hs ? (NUM_REQ'(1) << sel) : '0;
  assign req_word  = req_data[int'(sel)*DATA_W +: DATA_W];
  assign arb_busy  = (state_q == STREAM);

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    burst_d  = burst_q;
    rr_ptr_d = rr_ptr_q;
    if (rotate) begin
      if (bump_ptr) rr_ptr_d = owner_next;
      state_d = IDLE;
      burst_d = '0;
    end
    if (hs) begin
      if (state_q == STREAM && !rotate) begin
        if (!burst_full) burst_d = burst_q + 4'd1;
      end else begin
        state_d = STREAM;
        owner_d = sel;
        burst_d = 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      burst_q   <= '0;
      rr_ptr_q  <= '0;
      tlp_valid <= 1'b0;
      tlp_data  <= '0;
      grant_id  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      burst_q  <= burst_d;
      rr_ptr_q <= rr_ptr_d;
      if (hs) begin
        tlp_data  <= req_word;
        grant_id  <= sel;
        tlp_valid <= 1'b1;
      end else if (tlp_ready) begin
        tlp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tlp_tx_arbiter.sv
// Directed bench for tlp_tx_arbiter: reset, rotation, saturation, backpressure, preemption.
module tb_tlp_tx_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 1024;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [DATA_W-1:0]         tlp_data;
  logic                      tlp_valid;
  logic                      tlp_ready;
  logic [1:0]                grant_id;
  logic                      arb_busy;

  int checks   = 0;
  int failures = 0;
  logic [1:0] exp_q[$];

  tlp_tx_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .MAX_BURST(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_data  (req_data),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .tlp_data  (tlp_data),
    .tlp_valid (tlp_valid),
    .tlp_ready (tlp_ready),
    .grant_id  (grant_id),
    .arb_busy  (arb_busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] word_of(input int r, input int v);
    return 64'hC0DE_0000_0000_0000 | (64'(r) << 16) | 64'(v);
  endfunction

  // driver tasks
  task automatic set_data(input int r, input logic [63:0] w);
    req_data[r*DATA_W +: DATA_W] = {16{w}};
  endtask

  task automatic expect_out(input string tag, input logic [1:0] id, input logic [63:0] w);
    check({tag, "_valid"}, 64'(tlp_valid), 64'd1);
    check({tag, "_id"}, 64'(grant_id), 64'(id));
    check({tag, "_lo"}, tlp_data[63:0], w);
    check({tag, "_hi"}, tlp_data[DATA_W-1 -: 64], w);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    req_valid = '0;
    tlp_ready = 1'b1;
    @(posedge clk); #1;
    check("rst_drop_valid", 64'(tlp_valid), 64'd0);
    check("rst_busy", 64'(arb_busy), 64'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    tlp_ready = 1'b1;
    req_valid = '0;
    req_data  = '0;
    for (int r = 0; r < NUM_REQ; r++) set_data(r, word_of(r, 0));
    repeat (3) @(posedge clk);

    // reset state with every requester asking
    @(negedge clk);
    req_valid = 4'b1111;
    #1;
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_valid", 64'(tlp_valid), 64'd0);
    check("rst_id", 64'(grant_id), 64'd0);
    check("rst_data", tlp_data[63:0], 64'd0);
    check("rst_busy0", 64'(arb_busy), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("first_ready", 64'(req_ready), 64'b0001);

    // continuous round robin, bursts of 4
`ifdef TLP_ARB_CPL_PRIO_EN
    for (int i = 0; i < 17; i++) exp_q.push_back(2'd0);
`else
    for (int g = 0; g < 4; g++)
      for (int b = 0; b < 4; b++) exp_q.push_back(2'(g));
    exp_q.push_back(2'd0);
`endif
    while (exp_q.size() > 0) begin
      logic [1:0] e;
      @(posedge clk); #1;
      e = exp_q.pop_front();
      expect_out("rr", e, word_of(int'(e), 0));
    end

    // lone requester 2: ten back-to-back grants, burst count saturates
    do_reset();
    req_valid = 4'b0100;
    for (int n = 0; n < 10; n++) begin
      #1;
      check("solo_ready", 64'(req_ready), 64'b0100);
      @(posedge clk); #1;
      expect_out("solo", 2'd2, word_of(2, 0));
      check("solo_busy", 64'(arb_busy), 64'd1);
      @(negedge clk);
    end
    req_valid = 4'b0000;
    @(posedge clk); #1;
    check("drain_valid", 64'(tlp_valid), 64'd0);
    check("drain_busy", 64'(arb_busy), 64'd0);

    // backpressure holds the register; release loads the next TLP at once
    @(negedge clk);
    req_valid = 4'b0010;
    @(posedge clk); #1;
    expect_out("bp_load", 2'd1, word_of(1, 0));
    @(negedge clk);
    tlp_ready = 1'b0;
    set_data(1, word_of(1, 1));
    for (int n = 0; n < 5; n++) begin
      #1;
      check("bp_ready", 64'(req_ready), 64'd0);
      @(posedge clk); #1;
      expect_out("bp_hold", 2'd1, word_of(1, 0));
      @(negedge clk);
    end
    tlp_ready = 1'b1;
    #1;
    check("bp_release_ready", 64'(req_ready), 64'b0010);
    @(posedge clk); #1;
    expect_out("bp_new", 2'd1, word_of(1, 1));
    set_data(1, word_of(1, 0));

    // owner drops after two beats: pointer moves to 2, so 3 beats 0
    do_reset();
    req_valid = 4'b1010;
    for (int n = 0; n < 2; n++) begin
      @(posedge clk); #1;
      expect_out("drop_own", 2'd1, word_of(1, 0));
    end
    @(negedge clk);
    req_valid = 4'b1001;
    #1;
`ifdef TLP_ARB_CPL_PRIO_EN
    check("drop_ready", 64'(req_ready), 64'b0001);
    @(posedge clk); #1;
    expect_out("drop_next", 2'd0, word_of(0, 0));
`else
    check("drop_ready", 64'(req_ready), 64'b1000);
    @(posedge clk); #1;
    expect_out("drop_next", 2'd3, word_of(3, 0));
`endif

    // requester 1 streams to its burst limit while 0, 2 and 3 wait
    do_reset();
    req_valid = 4'b0010;
    @(posedge clk); #1;
    expect_out("prio_b1", 2'd1, word_of(1, 0));
    @(negedge clk);
    req_valid = 4'b1111;
    #1;
    check("prio_keep_ready", 64'(req_ready), 64'b0010);
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      expect_out("prio_burst", 2'd1, word_of(1, 0));
    end
    @(negedge clk); #1;
`ifdef TLP_ARB_CPL_PRIO_EN
    check("prio_ready", 64'(req_ready), 64'b0001);
    @(posedge clk); #1;
    expect_out("prio_next", 2'd0, word_of(0, 0));
`else
    check("prio_ready", 64'(req_ready), 64'b0100);
    @(posedge clk); #1;
    expect_out("prio_next", 2'd2, word_of(2, 0));
`endif

    @(negedge clk);
    req_valid = '0;
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
